// File: rtl/stream_out_buffer.sv
// Output stage of the image pipeline: a first-word-fall-through FIFO that
// feeds an AXI-Stream master. Frame boundaries (tlast, frame_done) come only
// from the count of accepted output beats.
module stream_out_buffer #(
    parameter int DATA_W           = 8,
    parameter int DEPTH            = 32,
    parameter int PROG_FULL_THRESH = 24,
    parameter int FRAME_PIXELS     = 262144
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_data_valid,
    input  logic [DATA_W-1:0]          i_data,
    output logic                       o_prog_full,
    output logic [$clog2(DEPTH):0]     o_level,
    output logic                       o_overflow,
    output logic                       o_data_valid,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_data_last,
    input  logic                       i_data_ready,
    output logic                       o_frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FRAME_PIXELS);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     beat_cnt;
    logic              push;
    logic              pop;
    logic [LW-1:0]     level_next;

    // Handshake decode and FWFT read port, all from registered state.
    // A full FIFO still accepts a pixel when a pop frees a slot on the same edge.
    always_comb begin
        o_data_valid = (o_level != '0);
        o_data       = mem[rd_ptr];
        o_data_last  = o_data_valid && (beat_cnt == CW'(FRAME_PIXELS - 1));
        pop          = o_data_valid & i_data_ready;
        push         = i_data_valid & ((o_level < LW'(DEPTH)) | pop);
        level_next   = o_level + LW'(push) - LW'(pop);
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    // Pointers, level/flags, frame beat counter and interrupt pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_level      <= '0;
            o_prog_full  <= 1'b0;
            o_overflow   <= 1'b0;
            beat_cnt     <= '0;
            o_frame_done <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            o_level     <= level_next;
            o_prog_full <= (level_next >= LW'(PROG_FULL_THRESH));
            if (i_data_valid && !push) begin
                o_overflow <= 1'b1;
            end
            if (pop) begin
                beat_cnt <= o_data_last ? '0 : beat_cnt + 1'b1;
            end
            o_frame_done <= pop & o_data_last;
        end
    end

endmodule

// File: tb/tb_stream_out_buffer.sv
// Bench for stream_out_buffer: a fixed vector table, hand-written corner
// sequences, and randomized traffic checked against a queue-based model.
module tb_stream_out_buffer;

    localparam int DW  = 8;
    localparam int DEP = 8;
    localparam int PFT = 6;
    localparam int FP  = 4;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_data_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          i_data_ready = 1'b0;
    logic          o_prog_full;
    logic [3:0]    o_level;
    logic          o_overflow;
    logic          o_data_valid;
    logic [DW-1:0] o_data;
    logic          o_data_last;
    logic          o_frame_done;

    stream_out_buffer #(
        .DATA_W(DW), .DEPTH(DEP), .PROG_FULL_THRESH(PFT), .FRAME_PIXELS(FP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_data_valid(i_data_valid), .i_data(i_data),
        .o_prog_full(o_prog_full), .o_level(o_level), .o_overflow(o_overflow),
        .o_data_valid(o_data_valid), .o_data(o_data), .o_data_last(o_data_last),
        .i_data_ready(i_data_ready), .o_frame_done(o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, total beats popped, sticky flags.
    logic [DW-1:0] mq[$];
    int            beats;
    bit            m_ovf;
    bit            m_fd;
    logic [DW-1:0] dut_out[$];
    int            fd_seen;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          r;
        logic          ev;
        logic [DW-1:0] ed;
        logic [3:0]    el;
        logic          epf;
        logic          eovf;
        logic          elast;
        logic          efd;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        beats = 0;
        m_ovf = 0;
        m_fd  = 0;
    endtask

    task automatic check_model();
        chk("valid", o_data_valid, mq.size() != 0);
        chk("level", o_level, mq.size());
        chk("prog_full", o_prog_full, mq.size() >= PFT);
        chk("overflow", o_overflow, m_ovf);
        chk("last", o_data_last, (mq.size() != 0) && (beats % FP == FP - 1));
        chk("frame_done", o_frame_done, m_fd);
        if (mq.size() != 0) chk("data", o_data, mq[0]);
    endtask

    // One clock: drive at negedge, model the edge, compare 1 time unit later.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
        bit            had;
        logic [DW-1:0] head;
        bit            pop;
        bit            push;
        @(negedge i_clk);
        i_data_valid = v;
        i_data       = d;
        i_data_ready = r;
        had  = (mq.size() != 0);
        head = had ? mq[0] : '0;
        if (o_data_valid && r) dut_out.push_back(o_data);
        @(posedge i_clk);
        pop  = had && r;
        push = v && ((mq.size() < DEP) || pop);
        m_fd = 0;
        if (pop) begin
            void'(mq.pop_front());
            beats++;
            if (beats % FP == 0) m_fd = 1;
        end
        if (push) mq.push_back(d);
        else if (v) m_ovf = 1;
        #1;
        check_model();
        if (had && !r) begin
            chk("stable_valid", o_data_valid, 1);
            chk("stable_data", o_data, head);
        end
        if (o_frame_done) fd_seen++;
    endtask

    task automatic do_reset();
        i_data_valid = 1'b0;
        i_data_ready = 1'b0;
        i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_clear();
        #1;
        chk("rst_valid", o_data_valid, 0);
        chk("rst_level", o_level, 0);
        chk("rst_pf", o_prog_full, 0);
        chk("rst_ovf", o_overflow, 0);
        chk("rst_last", o_data_last, 0);
        chk("rst_fd", o_frame_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            guard;
        int            pushed;
        logic [DW-1:0] in_log[$];
        logic          v;

        // {v, d, r, exp valid, exp data, exp level, exp pf, exp ovf, exp last, exp frame_done}
        tbl[0]  = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h00, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h00, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h00, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h00, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 8'h06, 1'b0, 1'b1, 8'h00, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h00, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 8'h00, 4'd8, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h01, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 4'd4, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h06, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h07, 4'd1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1};

        model_clear();
        fd_seen = 0;
        @(negedge i_clk);
        do_reset();

        // Single write, then asynchronous reset mid-cycle.
        step(1'b1, 8'h11, 1'b0);
        chk("t1_valid", o_data_valid, 1);
        chk("t1_data", o_data, 8'h11);
        chk("t1_level", o_level, 1);
        chk("t1_pf", o_prog_full, 0);
        #2;
        i_data_valid = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("async_valid", o_data_valid, 0);
        chk("async_level", o_level, 0);
        do_reset();

        // Table: fill to prog_full and full, overflow, drain across two frames.
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].v, tbl[i].d, tbl[i].r);
            chk("tbl_valid", o_data_valid, tbl[i].ev);
            chk("tbl_level", o_level, tbl[i].el);
            chk("tbl_pf", o_prog_full, tbl[i].epf);
            chk("tbl_ovf", o_overflow, tbl[i].eovf);
            chk("tbl_last", o_data_last, tbl[i].elast);
            chk("tbl_fd", o_frame_done, tbl[i].efd);
            if (tbl[i].ev) chk("tbl_data", o_data, tbl[i].ed);
        end
        step(1'b0, 8'h00, 1'b1);
        chk("ovf_sticky", o_overflow, 1);

        // Full FIFO with simultaneous push and pop: level holds, no drop.
        do_reset();
        for (int i = 0; i < DEP; i++) step(1'b1, 8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h50, 1'b1);
        chk("full_pp_level", o_level, 8);
        chk("full_pp_ovf", o_overflow, 0);
        for (int i = 0; i < DEP + 1; i++) step(1'b0, 8'h00, 1'b1);
        chk("full_pp_empty", o_level, 0);

        // Continuous streaming: back-to-back frames with no idle gap.
        do_reset();
        fd_seen = 0;
        for (int i = 0; i < 2 * FP; i++) step(1'b1, 8'h80 + 8'(i), 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("stream_fd_count", fd_seen, 2);

        // Randomized traffic, upstream throttled on the almost-full level.
        do_reset();
        fd_seen = 0;
        dut_out.delete();
        pushed = 0;
        guard = 0;
        while ((pushed < 100 || mq.size() != 0) && guard < 3000) begin
            logic [DW-1:0] d;
            d = 8'($urandom);
            v = (pushed < 100) && (mq.size() < PFT) && ($urandom_range(0, 1) == 1);
            if (v) begin
                in_log.push_back(d);
                pushed++;
            end
            step(v, d, $urandom_range(0, 1) == 1);
            guard++;
        end
        chk("rand_done", guard < 3000, 1);
        chk("rand_ovf", o_overflow, 0);
        chk("rand_fd_count", fd_seen, 25);
        chk("rand_out_count", dut_out.size(), 100);
        for (int i = 0; i < 100 && i < dut_out.size(); i++) chk("rand_seq", dut_out[i], in_log[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_out_buffer.md
Name: stream_out_buffer

Overview:
Parametrised, vendor-IP-free replacement for the output stage of the image-processing pipeline. It sits after the convolution engine and accepts a valid-only pixel stream into an internal first-word-fall-through FIFO. It presents an AXI-Stream master with per-frame last-beat marking and raises a programmable almost-full flag that upstream uses as its ready. It also pulses a frame-done interrupt and holds a sticky overflow flag.

Parameters:
DATA_W, 8, pixel width in bits
DEPTH, 32, FIFO entries; power of two, >= 4
PROG_FULL_THRESH, 24, o_prog_full asserts when stored level >= this; range 1..DEPTH
FRAME_PIXELS, 262144, output beats per frame (512x512); >= 2

Ports:
i_clk  in  1  clock; all logic on rising edge
i_rst  in  1  asynchronous, active-high reset
i_data_valid  in  1  input pixel strobe; no input ready, upstream throttles on o_prog_full
i_data  in  DATA_W  input pixel
o_prog_full  out  1  registered almost-full flag
o_level  out  $clog2(DEPTH)+1  registered count of stored entries
o_overflow  out  1  sticky: a pixel was dropped
o_data_valid  out  1  AXI-S tvalid
o_data  out  DATA_W  AXI-S tdata
o_data_last  out  1  AXI-S tlast, last beat of a frame
i_data_ready  in  1  AXI-S tready
o_frame_done  out  1  one-cycle interrupt pulse after the last beat of a frame is accepted

Behaviour:
- Reset (async assert, release on clock): wr_ptr/rd_ptr/level=0; frame counter=0; all outputs 0; stored contents discarded. Mid-frame reset loses partial frame, next beat after release is beat 0.
- pop = o_data_valid & i_data_ready.
- push = i_data_valid & (level<DEPTH | pop). Full with simultaneous pop: push accepted, level unchanged.
- i_data_valid while full and no pop: pixel dropped, o_overflow<=1 next edge, held until reset.
- Storage is a register array indexed by pointers of $clog2(DEPTH) bits with natural wrap. Pointers advance by 1 on push/pop respectively.
- FWFT: o_data_valid = (level!=0); o_data = mem[rd_ptr] combinationally from registered state. A push at edge N into an empty FIFO gives o_data_valid=1 during cycle after edge N. Latency 1 clock in to out.
- AXI-S rules: once o_data_valid=1 it stays 1 with o_data/o_data_last stable until pop (guaranteed since only pop removes entries).
- level_next = level + push - pop. o_level<=level_next. o_prog_full<=(level_next>=PROG_FULL_THRESH): same edge the level changes, no extra lag.
- Frame counter (width $clog2(FRAME_PIXELS)) counts pops. o_data_last = o_data_valid & (cnt==FRAME_PIXELS-1).
- Pop with o_data_last: cnt<=0, o_frame_done<=1 for exactly one cycle. Otherwise o_frame_done<=0.
- Back-to-back frames: no idle cycle required; beat 0 of next frame may pop in the cycle o_frame_done is high.
- Input side is unaware of frames; framing is derived purely from the output beat count.

Test Plan:
(Bench params: DEPTH=8, PROG_FULL_THRESH=6, FRAME_PIXELS=4, DATA_W=8.)
1. Reset then write 0x11 one cycle with ready=0 -> next cycle o_data_valid=1, o_data=0x11, o_level=1, o_prog_full=0. Assert i_rst async mid-cycle -> o_data_valid, o_level drop to 0 immediately.
2. Write 6 pixels, ready=0 -> o_prog_full=1 at the edge level reaches 6. Pop 1 -> o_prog_full=0 at level 5.
3. Write 8 pixels (0x00..0x07), ready=0, then 9th 0xAA -> level=8, o_overflow=1 sticky. Drain -> outputs 0x00..0x07 in order, 0xAA never appears.
4. Full FIFO with ready=1 and valid=1 same cycle -> level stays 8, new pixel appears in order, no overflow.
5. Stream 8 pixels, ready=1 continuously -> o_data_last high on beats 3 and 7. o_frame_done pulses one cycle after each, no gap between frames.
6. Random valid and ready (~50%) over 100 pixels, no overflow -> output sequence equals input sequence. tdata/tlast stable while valid&!ready. o_frame_done count = 25.
